mcycle_unit: RTL and testbench
==============================

MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 The block SHALL have these ports; all signals are synchronous to CLK:
- CLK  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request from the E stage to begin an operation.
- MCOp  in  2  operation select: 00 UMULL, 01 SMULL, 10 UDIV, 11 SDIV.
- Operand1  in  32  multiplicand or dividend.
- Operand2  in  32  multiplier or divisor.
- Result1  out  32  low product or quotient; feeds ALUResultE.
- Result2  out  32  high product or remainder; feeds MCResultHighE.
- Busy  out  1  stall request; drives the pipeline-register enables low.
- Done  out  1  one-cycle pulse; results are valid.

Function
REQ-002 The block SHALL implement FSM states IDLE, COMPUTE and DONE.
REQ-003 In IDLE with Start=1, the block SHALL latch MCOp, Operand1 and Operand2 on the clock edge, clear the iteration counter and enter COMPUTE.
REQ-004 The block SHALL drive Busy combinationally as (IDLE and Start) or COMPUTE, so the E stage stalls in the same cycle Start is asserted.
REQ-005 COMPUTE SHALL last exactly 32 cycles, performing one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle, with a 6-bit counter running 0..31.
REQ-006 When the counter reaches 31, the block SHALL enter DONE on the next edge.
REQ-007 In DONE, Done SHALL be 1 and Busy 0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-008 Latency: if Start is accepted at the edge ending cycle T, Done SHALL be high in cycle T+33, with Busy high in cycles T through T+32.
REQ-009 Result1 and Result2 SHALL update only on the edge entering DONE and SHALL hold until the next DONE or Reset.
REQ-010 Start SHALL be ignored in COMPUTE and in DONE.
REQ-011 Signed operations SHALL work on operand magnitudes:
- product negated (64-bit) when the operand signs differ;
- quotient negated when the signs differ;
- remainder takes the sign of the dividend.
REQ-012 UMULL and SMULL SHALL return the full 64-bit product: Result2 holds bits 63:32 and Result1 holds bits 31:0.
REQ-013 Divide by zero, signed or unsigned, SHALL return Result1=32'hFFFFFFFF and Result2=Operand1, with the full 33-cycle latency.
REQ-014 SDIV of 32'h80000000 by 32'hFFFFFFFF SHALL return Result1=32'h80000000 and Result2=0.
REQ-015 Operand inputs SHALL be ignored after the Start edge; changing them during COMPUTE SHALL NOT affect the result.

Reset
REQ-016 While Reset=1, the block SHALL set state=IDLE, counter=0, Result1=0, Result2=0, Done=0 and all internal operand and accumulator registers to 0.
REQ-017 While Reset=1, Busy SHALL be 0 regardless of Start.
REQ-018 Reset asserted in COMPUTE or DONE SHALL abort the operation with no Done pulse.
REQ-019 Reset SHALL take priority over Start when both are asserted in the same cycle.

Structure
REQ-020 A shared package mc_pkg SHALL hold:
- the MCOp encodings (MC_UMUL, MC_SMUL, MC_UDIV, MC_SDIV);
- the FSM state encoding;
- the width constant (32) and the iteration count (32).
REQ-021 The sign handling SHALL be one sub-module, mc_signfix, a combinational magnitude/negate helper instantiated for operand entry and for result correction; the rest of the datapath stays in mcycle_unit.

Verification
REQ-022 UMULL 7 x 6, Start at cycle 0 -> Busy high in cycles 0..32, Done in cycle 33, Result1=42, Result2=0.
REQ-023 SMULL 32'hFFFFFFFD (-3) x 5 -> Result1=32'hFFFFFFF1, Result2=32'hFFFFFFFF. UMULL 32'hFFFFFFFF x 32'hFFFFFFFF -> Result2=32'hFFFFFFFE, Result1=1.
REQ-024 SDIV -7 / 2 -> Result1=32'hFFFFFFFD, Result2=32'hFFFFFFFF. UDIV 100 / 0 -> Result1=32'hFFFFFFFF, Result2=100, Done in cycle 33.
REQ-025 Start re-asserted with new operands at cycles 5 and 33 of an operation -> both ignored; the first result is unchanged. A new Start at cycle 34 is accepted.
REQ-026 Reset pulsed at cycle 10 of COMPUTE -> the next cycle is IDLE, Busy=0, Result1=Result2=0, and no Done for that operation. SDIV 32'h80000000 / 32'hFFFFFFFF -> Result1=32'h80000000, Result2=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op encodings,
// FSM state encoding and datapath sizing.
package mc_pkg;

    localparam int MC_WIDTH = 32;
    localparam int MC_ITERS = 32;

    typedef enum logic [1:0] {
        MC_UMUL = 2'b00,
        MC_SMUL = 2'b01,
        MC_UDIV = 2'b10,
        MC_SDIV = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COMPUTE = 2'b01,
        ST_DONE    = 2'b10
    } mc_state_e;

endpackage

// File: rtl/mc_signfix.sv
// Conditional two's-complement negate; yields a magnitude on operand entry and
// restores the sign on result exit.
module mc_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mcycle_unit.sv
// Iterative 32x32 multiply / 32/32 divide, one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes.
//   state      | meaning
//   ST_IDLE    | waiting for Start; Busy follows Start
//   ST_COMPUTE | 32 iterations, counter 0..31
//   ST_DONE    | results valid, Done pulses for one cycle
module mcycle_unit
    import mc_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic [1:0]          MCOp,
    input  logic [MC_WIDTH-1:0] Operand1,
    input  logic [MC_WIDTH-1:0] Operand2,
    output logic [MC_WIDTH-1:0] Result1,
    output logic [MC_WIDTH-1:0] Result2,
    output logic                Busy,
    output logic                Done
);

    localparam logic [5:0] LAST_CNT = 6'(MC_ITERS - 1);

    mc_state_e           state_q;
    mc_op_e              op_q;
    logic [5:0]          cnt_q;
    logic [MC_WIDTH-1:0] m_q;
    logic [MC_WIDTH-1:0] hi_q;
    logic [MC_WIDTH-1:0] lo_q;
    logic                neg_q;
    logic                neg_rem_q;
    logic [MC_WIDTH-1:0] res1_q;
    logic [MC_WIDTH-1:0] res2_q;
    logic                done_q;

    mc_op_e                op_in;
    logic                  in_signed;
    logic                  in_div;
    logic                  is_div;
    logic [MC_WIDTH-1:0]   mag1;
    logic [MC_WIDTH-1:0]   mag2;
    logic [MC_WIDTH:0]     mul_sum;
    logic [MC_WIDTH:0]     trial;
    logic [MC_WIDTH-1:0]   diff;
    logic [MC_WIDTH-1:0]   hi_d;
    logic [MC_WIDTH-1:0]   lo_d;
    logic [2*MC_WIDTH-1:0] prod_fix;
    logic [MC_WIDTH-1:0]   quo_fix;
    logic [MC_WIDTH-1:0]   rem_fix;

    assign op_in     = mc_op_e'(MCOp);
    assign in_signed = (op_in == MC_SMUL) || (op_in == MC_SDIV);
    assign in_div    = (op_in == MC_UDIV) || (op_in == MC_SDIV);
    assign is_div    = (op_q == MC_UDIV) || (op_q == MC_SDIV);

    mc_signfix #(.W(MC_WIDTH)) u_mag1 (
        .val_i (Operand1),
        .neg_i (in_signed & Operand1[MC_WIDTH-1]),
        .val_o (mag1)
    );

    mc_signfix #(.W(MC_WIDTH)) u_mag2 (
        .val_i (Operand2),
        .neg_i (in_signed & Operand2[MC_WIDTH-1]),
        .val_o (mag2)
    );

    // hi holds the partial product / remainder, lo the multiplier / quotient.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign trial   = {hi_q, lo_q[MC_WIDTH-1]};
    assign diff    = trial[MC_WIDTH-1:0] - m_q;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div) begin
            if (trial >= {1'b0, m_q}) begin
                hi_d = diff;
                lo_d = {lo_q[MC_WIDTH-2:0], 1'b1};
            end else begin
                hi_d = trial[MC_WIDTH-1:0];
                lo_d = {lo_q[MC_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[MC_WIDTH:1];
            lo_d = {mul_sum[0], lo_q[MC_WIDTH-1:1]};
        end
    end

    mc_signfix #(.W(2*MC_WIDTH)) u_fix_prod (
        .val_i ({hi_d, lo_d}),
        .neg_i (neg_q),
        .val_o (prod_fix)
    );

    mc_signfix #(.W(MC_WIDTH)) u_fix_quo (
        .val_i (lo_d),
        .neg_i (neg_q),
        .val_o (quo_fix)
    );

    mc_signfix #(.W(MC_WIDTH)) u_fix_rem (
        .val_i (hi_d),
        .neg_i (neg_rem_q),
        .val_o (rem_fix)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= MC_UMUL;
            cnt_q     <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            res1_q    <= '0;
            res2_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        op_q  <= op_in;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        m_q   <= in_div ? mag2 : mag1;
                        lo_q  <= in_div ? mag1 : mag2;
                        // Divide by zero keeps the quotient unnegated so it stays all ones;
                        // the remainder correction then reproduces the dividend exactly.
                        neg_q     <= in_signed & (Operand1[MC_WIDTH-1] ^ Operand2[MC_WIDTH-1])
                                     & ~(in_div & (Operand2 == '0));
                        neg_rem_q <= in_signed & Operand1[MC_WIDTH-1];
                        state_q   <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        if (is_div) begin
                            res1_q <= quo_fix;
                            res2_q <= rem_fix;
                        end else begin
                            res1_q <= prod_fix[MC_WIDTH-1:0];
                            res2_q <= prod_fix[2*MC_WIDTH-1:MC_WIDTH];
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Busy    = ~Reset & (((state_q == ST_IDLE) & Start) | (state_q == ST_COMPUTE));
    assign Done    = done_q;
    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: stimulus pushes expected results, a monitor
// pops and compares them whenever Done is seen.
module tb_mcycle_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  MCOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mcycle_unit dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCOp     (MCOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2, input int c,
                            input string name);
        exp_t e;
        e.r1   = e1;
        e.r2   = e2;
        e.cyc  = c;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        #1;
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: Done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_r1"}, Result1, mon_e.r1);
                chk({mon_e.name, "_r2"}, Result2, mon_e.r2);
                chk({mon_e.name, "_done_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                chk({mon_e.name, "_busy_at_done"}, 32'(Busy), 32'd0);
            end
        end
    end

    // Called at the start cycle (after Start is set); walks to the first IDLE cycle.
    task automatic run_body(input logic [31:0] e1, input logic [31:0] e2, input string name);
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLK);
            Start    = 1'b0;
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCOp     = 2'($urandom_range(0, 3));
            #1 chk({name, "_busy"}, 32'(Busy), 32'(k <= 32));
        end
        @(negedge CLK);
        #1;
        chk({name, "_hold_r1"}, Result1, e1);
        chk({name, "_hold_r2"}, Result2, e2);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e1, input logic [31:0] e2, input string name);
        MCOp     = op;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        push_exp(e1, e2, cyc + 33, name);
        #1 chk({name, "_busy_start"}, 32'(Busy), 32'd1);
        run_body(e1, e2, name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset    = 1'b1;
        Start    = 1'b1;
        MCOp     = 2'b11;
        Operand1 = 32'h0000_1234;
        Operand2 = 32'h0000_0005;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            chk("rst_busy", 32'(Busy), 32'd0);
            chk("rst_done", 32'(Done), 32'd0);
            chk("rst_r1", Result1, 32'd0);
            chk("rst_r2", Result2, 32'd0);
        end
        @(negedge CLK);
        Reset = 1'b0;
        Start = 1'b0;
        #1 chk("rst_beats_start", 32'(Busy), 32'd0);
        @(negedge CLK);

        run_op(2'b00, 32'd7,          32'd6,          32'd42,         32'd0,          "umul_7x6");
        run_op(2'b01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  "smul_m3x5");
        run_op(2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  "umul_max");
        run_op(2'b01, 32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd6,          32'd0,          "smul_m2xm3");
        run_op(2'b01, 32'h8000_0000,  32'h8000_0000,  32'd0,          32'h4000_0000,  "smul_min2");
        run_op(2'b01, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  32'hFFFF_FFFF,  "smul_maxxm1");
        run_op(2'b00, 32'h8000_0000,  32'd2,          32'd0,          32'd1,          "umul_carry");
        run_op(2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  "sdiv_m7d2");
        run_op(2'b11, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          "sdiv_7dm2");
        run_op(2'b10, 32'd100,        32'd7,          32'd14,         32'd2,          "udiv_100d7");
        run_op(2'b10, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          "udiv_maxd1");
        run_op(2'b10, 32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        "udiv_by0");
        run_op(2'b11, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  "sdiv_m100_by0");
        run_op(2'b11, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  "sdiv_min_by0");
        run_op(2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          "sdiv_ovf");

        // Start during COMPUTE (cycle 5) and DONE (cycle 33) is ignored; cycle 34 is accepted.
        MCOp     = 2'b00;
        Operand1 = 32'd7;
        Operand2 = 32'd6;
        Start    = 1'b1;
        push_exp(32'd42, 32'd0, cyc + 33, "ignore_start");
        #1 chk("ignore_busy_start", 32'(Busy), 32'd1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge CLK);
            if (k == 5) begin
                Start = 1'b1; MCOp = 2'b11; Operand1 = 32'd99; Operand2 = 32'd3;
            end else if (k >= 33) begin
                Start = 1'b1; MCOp = 2'b00; Operand1 = 32'd3; Operand2 = 32'd3;
            end else begin
                Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
            end
            if (k == 34) push_exp(32'd9, 32'd0, cyc + 33, "restart");
            #1 chk("ignore_busy", 32'(Busy), 32'((k <= 32) || (k == 34)));
            if (k == 34) begin
                chk("ignore_hold_r1", Result1, 32'd42);
                chk("ignore_hold_r2", Result2, 32'd0);
            end
        end
        run_body(32'd9, 32'd0, "restart");

        // Reset in the middle of COMPUTE aborts with no Done and clears the results.
        MCOp     = 2'b11;
        Operand1 = 32'd50;
        Operand2 = 32'd5;
        Start    = 1'b1;
        #1 chk("abort_busy_start", 32'(Busy), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            Start = 1'b0;
            if (k == 10) begin
                Reset = 1'b1;
                Start = 1'b1;
            end
            #1 chk("abort_busy", 32'(Busy), 32'(k < 10));
        end
        @(negedge CLK);
        Reset = 1'b0;
        Start = 1'b0;
        #1;
        chk("abort_idle_busy", 32'(Busy), 32'd0);
        chk("abort_r1", Result1, 32'd0);
        chk("abort_r2", Result2, 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        repeat (40) @(negedge CLK);

        run_op(2'b10, 32'd100, 32'd7, 32'd14, 32'd2, "after_abort");

        repeat (3) @(negedge CLK);
        chk("outstanding_ops", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
